// File: rtl/cdm_err_sweep.sv
// Exhaustive error sweep of an external 2W-bit-product multiplier: error count, max and sum of |a*b - r|.
// Latency: done in cycle 2^(2W)+MUL_LAT+1 after the start edge; one operand pair issued per cycle.
// Backpressure: none; the multiplier must accept a pair every cycle, and start is ignored unless IDLE.
module cdm_err_sweep #(
    parameter int W       = 8,
    parameter int MUL_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_r,
    output logic [2*W:0]     err_cnt,
    output logic [2*W-1:0]   max_ed,
    output logic [4*W-1:0]   sum_ed
);

    localparam int PW = 2 * W;
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'((MUL_LAT > 0) ? MUL_LAT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t          state;
    logic [CW-1:0]   drain_cnt;
    logic            issue_vld;
    logic            last_pair;
    logic            sc_vld;
    logic [W-1:0]    sc_a;
    logic [W-1:0]    sc_b;
    logic [PW-1:0]   exact_p;
    logic [PW:0]     ed;
    logic            ed_nz;

    assign issue_vld = (state == S_RUN);
    assign last_pair = &{mul_a, mul_b};

    // Operands travel alongside the multiplier so each result is scored against its own pair.
    generate
        if (MUL_LAT == 0) begin : g_nodly
            assign sc_vld = issue_vld;
            assign sc_a   = mul_a;
            assign sc_b   = mul_b;
        end else begin : g_dly
            logic [MUL_LAT-1:0] vld_q;
            logic [W-1:0]       a_q [MUL_LAT];
            logic [W-1:0]       b_q [MUL_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= issue_vld;
                    for (int i = 1; i < MUL_LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                    end
                end
                a_q[0] <= mul_a;
                b_q[0] <= mul_b;
                for (int i = 1; i < MUL_LAT; i++) begin
                    a_q[i] <= a_q[i-1];
                    b_q[i] <= b_q[i-1];
                end
            end

            assign sc_vld = vld_q[MUL_LAT-1];
            assign sc_a   = a_q[MUL_LAT-1];
            assign sc_b   = b_q[MUL_LAT-1];
        end
    endgenerate

    assign exact_p = PW'(sc_a) * PW'(sc_b);

    always_comb begin
        ed = '0;
        if (exact_p >= mul_r) begin
            ed = {1'b0, exact_p} - {1'b0, mul_r};
        end else begin
            ed = {1'b0, mul_r} - {1'b0, exact_p};
        end
    end

    assign ed_nz = (ed != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            drain_cnt <= '0;
            err_cnt   <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else begin
            if (sc_vld) begin
                err_cnt <= err_cnt + {{PW{1'b0}}, ed_nz};
                sum_ed  <= sum_ed + (4*W)'(ed);
                if (ed[PW-1:0] > max_ed) begin
                    max_ed <= ed[PW-1:0];
                end
            end

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= S_RUN;
                        busy    <= 1'b1;
                        mul_a   <= '0;
                        mul_b   <= '0;
                        err_cnt <= '0;
                        max_ed  <= '0;
                        sum_ed  <= '0;
                    end
                end
                S_RUN: begin
                    if (last_pair) begin
                        drain_cnt <= '0;
                        if (MUL_LAT == 0) begin
                            state <= S_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        {mul_a, mul_b} <= {mul_a, mul_b} + PW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
